// File: rtl/apb_master.sv
// APB master: accepts one command at a time and runs a single APB transfer.
// A transfer that times out returns an error response.
module apb_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [8:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [8:0]  paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic        pready,
    input  logic [31:0] prdata
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [8:0] CNT_LAST = 9'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [8:0]  r_cnt;
    logic [8:0]  r_paddr;
    logic        r_psel;
    logic        r_penable;
    logic        r_pwrite;
    logic [31:0] r_pwdata;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_error;
    logic        w_accept;
    logic        w_done;
    logic        w_tmo;

    assign cmd_ready = (r_state == IDLE);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_done    = (r_state == ACCESS) && pready;
    // Completion beats timeout when pready arrives on the final allowed cycle.
    assign w_tmo     = (r_state == ACCESS) && !pready && (r_cnt == CNT_LAST);

    assign paddr     = r_paddr;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign pwdata    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = SETUP;
            SETUP:   w_next = ACCESS;
            ACCESS:  if (w_done || w_tmo) w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_paddr     <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_paddr   <= cmd_addr;
                        r_pwrite  <= cmd_write;
                        r_pwdata  <= cmd_write ? cmd_wdata : 32'h0;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_cnt     <= '0;
                end
                ACCESS: begin
                    if (w_done) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= 1'b0;
                        r_rsp_rdata <= r_pwrite ? 32'h0 : prdata;
                    end else if (w_tmo) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= 1'b1;
                        r_rsp_rdata <= 32'h0;
                    end else begin
                        r_cnt <= r_cnt + 9'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) r_rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
